// File: rtl/iomem_scheduler.sv
// iomem_scheduler: shares the single iomem block-memory port between
// I-cache refill (0), D-cache refill/writeback (1) and an auxiliary master (2).
// Round-robin arbitration, exactly one transaction in flight, response routed
// back to its owner, and a BUSY-cycle timeout that aborts unacknowledged
// transactions with an error response.
module iomem_scheduler #(
    parameter int XLEN        = 32,
    parameter int BLK_SIZE    = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [2:0]               req_valid_i,
    output logic [2:0]               req_ready_o,
    input  logic [2:0][XLEN-1:0]     req_addr_i,
    input  logic [2:0][BLK_SIZE-1:0] req_wdata_i,
    input  logic [2:0][15:0]         req_wstrb_i,
    output logic [2:0]               rsp_valid_o,
    output logic                     rsp_err_o,
    output logic [BLK_SIZE-1:0]      rsp_rdata_o,
    output logic                     iomem_valid_o,
    input  logic                     iomem_ready_i,
    output logic [XLEN-1:0]          iomem_addr_o,
    output logic [BLK_SIZE-1:0]      iomem_wdata_o,
    output logic [15:0]              iomem_wstrb_o,
    input  logic [BLK_SIZE-1:0]      iomem_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter only has to reach TIMEOUT_CYC-1; keep at least one bit when disabled.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Next requester index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] next_req(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // One-hot strobe for a requester index.
    function automatic logic [2:0] req_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    logic [1:0]          state_r;
    logic [1:0]          last_grant_r;
    logic [1:0]          owner_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                iomem_valid_r;
    logic [XLEN-1:0]     addr_r;
    logic [BLK_SIZE-1:0] wdata_r;
    logic [15:0]         wstrb_r;
    logic [BLK_SIZE-1:0] rdata_r;
    logic                err_r;
    logic [2:0]          rsp_valid_r;

    logic [1:0]          cand0_s;
    logic [1:0]          cand1_s;
    logic [1:0]          cand2_s;
    logic [1:0]          grant_idx_s;
    logic                grant_vld_s;
    logic [2:0]          req_ready_s;
    logic                timeout_s;

    // Rotating-priority pick: the requester after the last grant is tried first.
    always_comb begin
        cand0_s     = next_req(last_grant_r);
        cand1_s     = next_req(cand0_s);
        cand2_s     = next_req(cand1_s);
        grant_idx_s = 2'd0;
        grant_vld_s = 1'b0;
        if (req_valid_i[cand0_s]) begin
            grant_idx_s = cand0_s;
            grant_vld_s = 1'b1;
        end else if (req_valid_i[cand1_s]) begin
            grant_idx_s = cand1_s;
            grant_vld_s = 1'b1;
        end else if (req_valid_i[cand2_s]) begin
            grant_idx_s = cand2_s;
            grant_vld_s = 1'b1;
        end else begin
            grant_idx_s = 2'd0;
            grant_vld_s = 1'b0;
        end
    end

    // Accept strobe exists only in IDLE and is suppressed while reset is held.
    always_comb begin
        req_ready_s = 3'b000;
        if (rst_ni && (state_r == ST_IDLE) && grant_vld_s) begin
            req_ready_s = req_onehot(grant_idx_s);
        end else begin
            req_ready_s = 3'b000;
        end
    end

    // Abort condition: the last allowed BUSY cycle passes without an acknowledge.
    always_comb begin
        timeout_s = 1'b0;
        if ((TIMEOUT_CYC != 0) && (cnt_r == CNT_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Transaction FSM: capture on accept, hold the port in BUSY, one-cycle response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 2'd2;
            owner_r       <= 2'd0;
            cnt_r         <= {CNT_W{1'b0}};
            iomem_valid_r <= 1'b0;
            addr_r        <= {XLEN{1'b0}};
            wdata_r       <= {BLK_SIZE{1'b0}};
            wstrb_r       <= 16'h0000;
            rdata_r       <= {BLK_SIZE{1'b0}};
            err_r         <= 1'b0;
            rsp_valid_r   <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        addr_r        <= req_addr_i[grant_idx_s];
                        wdata_r       <= req_wdata_i[grant_idx_s];
                        wstrb_r       <= req_wstrb_i[grant_idx_s];
                        last_grant_r  <= grant_idx_s;
                        owner_r       <= grant_idx_s;
                        cnt_r         <= {CNT_W{1'b0}};
                        iomem_valid_r <= 1'b1;
                        state_r       <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (iomem_ready_i) begin
                        // Read data is captured for writes as well.
                        rdata_r       <= iomem_rdata_i;
                        err_r         <= 1'b0;
                        iomem_valid_r <= 1'b0;
                        rsp_valid_r   <= req_onehot(owner_r);
                        state_r       <= ST_RESP;
                    end else if (timeout_s) begin
                        rdata_r       <= {BLK_SIZE{1'b0}};
                        err_r         <= 1'b1;
                        iomem_valid_r <= 1'b0;
                        rsp_valid_r   <= req_onehot(owner_r);
                        state_r       <= ST_RESP;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= 3'b000;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    iomem_valid_r <= 1'b0;
                    rsp_valid_r   <= 3'b000;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_s;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_err_o     = err_r;
    assign rsp_rdata_o   = rdata_r;
    assign iomem_valid_o = iomem_valid_r;
    assign iomem_addr_o  = addr_r;
    assign iomem_wdata_o = wdata_r;
    assign iomem_wstrb_o = wstrb_r;

endmodule

// File: tb/tb_iomem_scheduler.sv
// Self-checking bench for iomem_scheduler. The reference model works at
// transaction level: rotating-priority grant from the last winner, response
// one cycle after the acknowledge, or an error response after the timeout.
module tb_iomem_scheduler;

    localparam int XLEN = 32;
    localparam int BLK  = 128;
    localparam int TO   = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [2:0]          req_valid_i;
    logic [2:0]          req_ready_o;
    logic [2:0][XLEN-1:0] req_addr_i;
    logic [2:0][BLK-1:0] req_wdata_i;
    logic [2:0][15:0]    req_wstrb_i;
    logic [2:0]          rsp_valid_o;
    logic                rsp_err_o;
    logic [BLK-1:0]      rsp_rdata_o;
    logic                iomem_valid_o;
    logic                iomem_ready_i;
    logic [XLEN-1:0]     iomem_addr_o;
    logic [BLK-1:0]      iomem_wdata_o;
    logic [15:0]         iomem_wstrb_o;
    logic [BLK-1:0]      iomem_rdata_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_last = 2;

    // Observations of the last transaction driven by run_txn.
    logic [2:0]      r_acc;
    logic [2:0]      r_rv;
    logic [XLEN-1:0] r_a1;
    logic [BLK-1:0]  r_w1;
    logic [15:0]     r_s1;
    logic [BLK-1:0]  r_rd;
    logic            r_re;
    logic            r_chg;
    logic            r_brdy;
    int              r_cyc;
    int              r_vcnt;

    always #5 clk_i = ~clk_i;

    iomem_scheduler #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT_CYC(TO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wstrb_i  (req_wstrb_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .iomem_valid_o(iomem_valid_o),
        .iomem_ready_i(iomem_ready_i),
        .iomem_addr_o (iomem_addr_o),
        .iomem_wdata_o(iomem_wdata_o),
        .iomem_wstrb_o(iomem_wstrb_o),
        .iomem_rdata_i(iomem_rdata_i)
    );

    // Model: first valid requester starting at (last+1) mod 3, -1 if none.
    function automatic int exp_grant(input logic [2:0] mask, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (mask[(last + i) % 3]) return (last + i) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int idx);
        logic [2:0] v;
        v = 3'b000;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [BLK-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one transaction: vmask valid in cycle 0, memory acknowledge in
    // cycle lat (never if lat is beyond the window). mode 0 drops the winner's
    // valid after accept, 1 keeps everything, 2 scrambles valid/addr in BUSY.
    task automatic run_txn(input logic [2:0] vmask, input int lat,
                           input logic [BLK-1:0] mdata, input int mode);
        r_acc = 3'b000; r_rv = 3'b000; r_a1 = '0; r_w1 = '0; r_s1 = '0;
        r_rd = '0; r_re = 1'b0; r_chg = 1'b0; r_brdy = 1'b0;
        r_cyc = -1; r_vcnt = 0;
        @(posedge clk_i); #1;
        req_valid_i   = vmask;
        iomem_ready_i = 1'b0;
        #1;
        r_acc = req_ready_o;
        for (int c = 1; c <= 40; c++) begin
            if (r_cyc >= 0) break;
            @(posedge clk_i); #1;
            iomem_ready_i = (c == lat);
            iomem_rdata_i = (c == lat) ? mdata : rnd_blk();
            if (mode == 0) begin
                req_valid_i = req_valid_i & ~r_acc;
            end else if (mode == 2) begin
                req_valid_i = 3'($urandom_range(0, 7));
                for (int k = 0; k < 3; k++) req_addr_i[k] = $urandom;
            end
            #1;
            if (iomem_valid_o) r_vcnt++;
            if (req_ready_o !== 3'b000) r_brdy = 1'b1;
            if (c == 1) begin
                r_a1 = iomem_addr_o; r_w1 = iomem_wdata_o; r_s1 = iomem_wstrb_o;
            end else if (iomem_valid_o && ({iomem_addr_o, iomem_wdata_o, iomem_wstrb_o}
                                           !== {r_a1, r_w1, r_s1})) begin
                r_chg = 1'b1;
            end
            if (rsp_valid_o !== 3'b000) begin
                r_cyc = c; r_rv = rsp_valid_o; r_re = rsp_err_o; r_rd = rsp_rdata_o;
            end
        end
        req_valid_i = 3'b000;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = 3'b111;
        #12;
        n_cmp++; if (req_ready_o !== 3'b000) begin n_fail++;
            $display("FAIL reset_ready: got %b want 000", req_ready_o); end
        n_cmp++; if ({iomem_valid_o, rsp_valid_o, rsp_err_o} !== 5'b0) begin n_fail++;
            $display("FAIL reset_valids: got %b want 00000", {iomem_valid_o, rsp_valid_o, rsp_err_o}); end
        n_cmp++; if ({iomem_addr_o, iomem_wdata_o, iomem_wstrb_o, rsp_rdata_o} !== '0) begin n_fail++;
            $display("FAIL reset_data: got addr %h wstrb %h rdata %h want 0",
                     iomem_addr_o, iomem_wstrb_o, rsp_rdata_o); end
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== onehot(exp_grant(3'b111, model_last))) begin n_fail++;
            $display("FAIL reset_first_grant: got %b want %b", req_ready_o,
                     onehot(exp_grant(3'b111, model_last))); end
        req_valid_i = 3'b000;
    endtask

    task automatic test_single_read();
        logic [BLK-1:0] d;
        int g;
        d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        req_addr_i[0] = 32'h8000_0010; req_wstrb_i[0] = 16'h0000; req_wdata_i[0] = rnd_blk();
        g = exp_grant(3'b001, model_last);
        run_txn(3'b001, 2, d, 0);
        model_last = g;
        n_cmp++; if (r_acc !== 3'b001) begin n_fail++;
            $display("FAIL read_accept: got %b want 001", r_acc); end
        n_cmp++; if ({r_a1, r_s1} !== {32'h8000_0010, 16'h0000}) begin n_fail++;
            $display("FAIL read_addr: got %h/%h want 80000010/0000", r_a1, r_s1); end
        n_cmp++; if ({r_cyc, r_vcnt} !== {32'd3, 32'd2}) begin n_fail++;
            $display("FAIL read_latency: got rsp cycle %0d valid cycles %0d want 3/2", r_cyc, r_vcnt); end
        n_cmp++; if ({r_rv, r_re, r_rd} !== {3'b001, 1'b0, d}) begin n_fail++;
            $display("FAIL read_rsp: got %b %b %h want 001 0 %h", r_rv, r_re, r_rd, d); end
        @(posedge clk_i); #2;
        n_cmp++; if ({rsp_valid_o, rsp_rdata_o} !== {3'b000, d}) begin n_fail++;
            $display("FAIL read_hold: got %b %h want 000 %h", rsp_valid_o, rsp_rdata_o, d); end
    endtask

    task automatic test_write_routing();
        int g;
        req_addr_i[1] = $urandom; req_wdata_i[1] = {16{8'hA5}}; req_wstrb_i[1] = 16'hFFFF;
        req_addr_i[2] = $urandom; req_wdata_i[2] = rnd_blk(); req_wstrb_i[2] = 16'h0000;
        g = exp_grant(3'b110, model_last);
        run_txn(3'b110, 3, rnd_blk(), 0);
        model_last = g;
        n_cmp++; if (r_acc !== onehot(g)) begin n_fail++;
            $display("FAIL write_accept: got %b want %b", r_acc, onehot(g)); end
        n_cmp++; if ({r_w1, r_s1, r_a1} !== {req_wdata_i[g], req_wstrb_i[g], req_addr_i[g]}) begin
            n_fail++; $display("FAIL write_fields: got %h %h want %h %h",
                               r_s1, r_w1, req_wstrb_i[g], req_wdata_i[g]); end
        n_cmp++; if ({r_chg, r_cyc, r_rv} !== {1'b0, 32'd4, onehot(g)}) begin n_fail++;
            $display("FAIL write_hold_rsp: got chg %b cyc %0d rsp %b want 0 4 %b",
                     r_chg, r_cyc, r_rv, onehot(g)); end
        g = exp_grant(3'b100, model_last);
        run_txn(3'b100, 1, rnd_blk(), 0);
        model_last = g;
        n_cmp++; if ({r_acc, r_a1} !== {3'b100, req_addr_i[2]}) begin n_fail++;
            $display("FAIL write_next: got %b %h want 100 %h", r_acc, r_a1, req_addr_i[2]); end
    endtask

    task automatic test_round_robin();
        int g;
        for (int k = 0; k < 3; k++) req_addr_i[k] = $urandom;
        for (int n = 0; n < 6; n++) begin
            g = exp_grant(3'b111, model_last);
            run_txn(3'b111, 1, rnd_blk(), 1);
            model_last = g;
            n_cmp++; if ({r_acc, r_rv} !== {onehot(g), onehot(g)}) begin n_fail++;
                $display("FAIL rr_grant%0d: got acc %b rsp %b want %b", n, r_acc, r_rv, onehot(g)); end
            n_cmp++; if ({r_cyc, r_brdy} !== {32'd2, 1'b0}) begin n_fail++;
                $display("FAIL rr_timing%0d: got cyc %0d brdy %b want 2 0", n, r_cyc, r_brdy); end
        end
    endtask

    task automatic test_timeout();
        int g;
        g = exp_grant(3'b010, model_last);
        run_txn(3'b010, 1000, rnd_blk(), 0);
        model_last = g;
        n_cmp++; if ({r_acc, r_rv} !== {onehot(g), onehot(g)}) begin n_fail++;
            $display("FAIL to_owner: got acc %b rsp %b want %b", r_acc, r_rv, onehot(g)); end
        n_cmp++; if ({r_cyc, r_vcnt} !== {TO + 1, TO}) begin n_fail++;
            $display("FAIL to_cycle: got cyc %0d vcnt %0d want %0d %0d", r_cyc, r_vcnt, TO + 1, TO); end
        n_cmp++; if ({r_re, r_rd} !== {1'b1, {BLK{1'b0}}}) begin n_fail++;
            $display("FAIL to_err: got err %b rdata %h want 1 0", r_re, r_rd); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk_i); #1;
            iomem_ready_i = 1'b1; iomem_rdata_i = rnd_blk();
            #1;
            n_cmp++; if ({rsp_valid_o, iomem_valid_o, rsp_err_o} !== 5'b00001) begin n_fail++;
                $display("FAIL to_late_ready%0d: got %b want 00001",
                         n, {rsp_valid_o, iomem_valid_o, rsp_err_o}); end
        end
        iomem_ready_i = 1'b0;
    endtask

    task automatic test_stability();
        int g;
        logic [XLEN-1:0] a;
        a = $urandom; req_addr_i[2] = a;
        g = exp_grant(3'b100, model_last);
        run_txn(3'b100, 4, rnd_blk(), 2);
        model_last = g;
        n_cmp++; if ({r_acc, r_a1} !== {3'b100, a}) begin n_fail++;
            $display("FAIL stab_capture: got %b %h want 100 %h", r_acc, r_a1, a); end
        n_cmp++; if ({r_chg, r_brdy, r_cyc} !== {1'b0, 1'b0, 32'd5}) begin n_fail++;
            $display("FAIL stab_hold: got chg %b brdy %b cyc %0d want 0 0 5", r_chg, r_brdy, r_cyc); end
    endtask

    task automatic test_random();
        int g, lat, ecyc;
        logic [2:0] mask;
        logic [BLK-1:0] md, erd;
        for (int n = 0; n < 25; n++) begin
            mask = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) begin
                req_addr_i[k]  = $urandom;
                req_wdata_i[k] = rnd_blk();
                req_wstrb_i[k] = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            end
            lat = $urandom_range(1, TO + 2);
            md  = rnd_blk();
            g   = exp_grant(mask, model_last);
            ecyc = (lat <= TO) ? lat + 1 : TO + 1;
            erd  = (lat <= TO) ? md : {BLK{1'b0}};
            run_txn(mask, lat, md, 0);
            model_last = g;
            n_cmp++; if ({r_acc, r_rv} !== {onehot(g), onehot(g)}) begin n_fail++;
                $display("FAIL rnd_grant%0d: mask %b got %b/%b want %b", n, mask, r_acc, r_rv, onehot(g)); end
            n_cmp++; if ({r_a1, r_w1, r_s1} !== {req_addr_i[g], req_wdata_i[g], req_wstrb_i[g]}) begin
                n_fail++; $display("FAIL rnd_fields%0d: got %h %h want %h %h",
                                   n, r_a1, r_s1, req_addr_i[g], req_wstrb_i[g]); end
            n_cmp++; if ({r_cyc, r_vcnt, r_chg, r_brdy} !== {ecyc, ecyc - 1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL rnd_timing%0d: lat %0d got cyc %0d vcnt %0d want %0d",
                                   n, lat, r_cyc, r_vcnt, ecyc); end
            n_cmp++; if ({r_re, r_rd} !== {(lat > TO), erd}) begin n_fail++;
                $display("FAIL rnd_rsp%0d: got %b %h want %b %h", n, r_re, r_rd, (lat > TO), erd); end
        end
    endtask

    task automatic test_reset_mid_busy();
        int g;
        req_addr_i[0] = $urandom; req_addr_i[2] = $urandom;
        @(posedge clk_i); #1;
        req_valid_i = 3'b001;
        @(posedge clk_i); #1;
        req_valid_i = 3'b101;
        #1;
        n_cmp++; if (iomem_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL mid_busy_valid: got %b want 1", iomem_valid_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++; if ({iomem_valid_o, req_ready_o} !== 4'b0000) begin n_fail++;
            $display("FAIL mid_async_drop: got %b want 0000", {iomem_valid_o, req_ready_o}); end
        for (int n = 0; n < 2; n++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (rsp_valid_o !== 3'b000) begin n_fail++;
                $display("FAIL mid_stale%0d: got %b want 000", n, rsp_valid_o); end
        end
        req_valid_i = 3'b000;
        rst_ni = 1'b1;
        model_last = 2;
        for (int n = 0; n < 2; n++) begin
            g = exp_grant(3'b101, model_last);
            run_txn(3'b101, 2, rnd_blk(), 0);
            model_last = g;
            n_cmp++; if ({r_acc, r_rv, r_cyc, r_a1} !== {onehot(g), onehot(g), 32'd3, req_addr_i[g]}) begin
                n_fail++; $display("FAIL mid_regrant%0d: got %b %b %0d want %b 3",
                                   n, r_acc, r_rv, r_cyc, onehot(g)); end
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 3'b000;
        req_addr_i    = '0;
        req_wdata_i   = '0;
        req_wstrb_i   = '0;
        iomem_ready_i = 1'b0;
        iomem_rdata_i = '0;
        test_reset();
        test_single_read();
        test_write_routing();
        test_round_robin();
        test_timeout();
        test_stability();
        test_random();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
